// File: rtl/rv_p4_pkg.sv
// Shared constants and types for the match-action TCAM pipeline.
package rv_p4_pkg;

    localparam int unsigned MAU_TCAM_KEY_W = 512;
    localparam int unsigned MAU_TCAM_DEPTH = 2048;

    typedef struct packed {
        logic [15:0] action_id;
        logic [15:0] action_ptr;
    } tcam_action_t;

endpackage

// File: rtl/mau_tcam_bank.sv
// One contiguous slice of TCAM entries: storage, ternary match, local priority
// encoder and the stage-A snapshot of the winning entry.
module mau_tcam_bank
    import rv_p4_pkg::*;
#(
    parameter int unsigned KEY_W   = MAU_TCAM_KEY_W,
    parameter int unsigned ENT     = 512,
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned LADDR_W = 9,
    parameter int unsigned BANK_ID = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [KEY_W-1:0]    wr_key,
    input  logic [KEY_W-1:0]    wr_mask,
    input  tcam_action_t        wr_action,
    input  logic                wr_valid,
    input  logic                clr_en,
    input  logic [ADDR_W-1:0]   clr_addr,
    input  logic                cap_en,
    input  logic [KEY_W-1:0]    key,
    output logic                hit,
    output logic [LADDR_W-1:0]  idx,
    output tcam_action_t        action
);

    logic [KEY_W-1:0]    key_mem_r  [ENT];
    logic [KEY_W-1:0]    mask_mem_r [ENT];
    tcam_action_t        act_mem_r  [ENT];
    logic [ENT-1:0]      valid_r;

    logic                wr_sel_s;
    logic                clr_sel_s;
    logic                hit_s;
    logic [LADDR_W-1:0]  loc_s;
    logic                hit_r;
    logic [LADDR_W-1:0]  idx_r;
    tcam_action_t        act_r;

    function automatic logic in_bank(input logic [ADDR_W-1:0] a);
        return (a >> LADDR_W) == ADDR_W'(BANK_ID);
    endfunction

    assign wr_sel_s  = wr_en && in_bank(wr_addr);
    assign clr_sel_s = clr_en && in_bank(clr_addr);

    // Key, mask and action storage; deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_sel_s) begin
            key_mem_r[wr_addr[LADDR_W-1:0]]  <= wr_key;
            mask_mem_r[wr_addr[LADDR_W-1:0]] <= wr_mask;
            act_mem_r[wr_addr[LADDR_W-1:0]]  <= wr_action;
        end
    end

    // Entry valid bits: written by the host port, cleared by the sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
        end else begin
            if (wr_sel_s) begin
                valid_r[wr_addr[LADDR_W-1:0]] <= wr_valid;
            end
            if (clr_sel_s) begin
                valid_r[clr_addr[LADDR_W-1:0]] <= 1'b0;
            end
        end
    end

    // Ternary match with lowest-index priority (scan downward, last hit wins)
    always_comb begin
        hit_s = 1'b0;
        loc_s = '0;
        for (int i = ENT - 1; i >= 0; i--) begin
            if (valid_r[i] && (((key ^ key_mem_r[i]) & ~mask_mem_r[i]) == '0)) begin
                hit_s = 1'b1;
                loc_s = LADDR_W'(i);
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // Stage-A snapshot; action is copied here so later writes cannot alter it
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_r <= 1'b0;
            idx_r <= '0;
            act_r <= '0;
        end else if (cap_en) begin
            hit_r <= hit_s;
            idx_r <= loc_s;
            act_r <= act_mem_r[loc_s];
        end
    end

    assign hit    = hit_r;
    assign idx    = idx_r;
    assign action = act_r;

endmodule

// File: rtl/mau_tcam_pipe.sv
// Two-stage banked TCAM lookup pipeline with in-order responses, a valid-bit
// clear sweep and saturating lookup/hit statistics.
module mau_tcam_pipe
    import rv_p4_pkg::*;
#(
    parameter int unsigned KEY_W  = MAU_TCAM_KEY_W,
    parameter int unsigned DEPTH  = MAU_TCAM_DEPTH,
    parameter int unsigned BANKS  = 4,
    parameter int unsigned TAG_W  = 8,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [KEY_W-1:0]   req_key,
    input  logic [TAG_W-1:0]   req_tag,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_hit,
    output logic [ADDR_W-1:0]  rsp_idx,
    output logic [15:0]        rsp_action_id,
    output logic [15:0]        rsp_action_ptr,
    output logic [TAG_W-1:0]   rsp_tag,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [KEY_W-1:0]   wr_key,
    input  logic [KEY_W-1:0]   wr_mask,
    input  logic [15:0]        wr_action_id,
    input  logic [15:0]        wr_action_ptr,
    input  logic               wr_valid,
    input  logic [15:0]        miss_action_id,
    input  logic [15:0]        miss_action_ptr,
    input  logic               clr_start,
    output logic               clr_busy,
    output logic [31:0]        lookup_cnt,
    output logic [31:0]        hit_cnt
);

    localparam int unsigned ENT     = DEPTH / BANKS;
    localparam int unsigned LADDR_W = $clog2(ENT);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]          state_r;
    logic [ADDR_W-1:0]   clr_addr_r;
    logic                clr_busy_s;
    logic                stall_s;
    logic                accept_s;
    logic                rsp_fire_s;
    logic                clr_accept_s;
    logic                wr_en_s;
    tcam_action_t        wr_act_s;

    logic                a_valid_r;
    logic [TAG_W-1:0]    a_tag_r;
    logic                bank_hit_s [BANKS];
    logic [LADDR_W-1:0]  bank_idx_s [BANKS];
    tcam_action_t        bank_act_s [BANKS];

    logic                sel_hit_s;
    logic [ADDR_W-1:0]   sel_idx_s;
    tcam_action_t        sel_act_s;

    logic                rsp_valid_r;
    logic                rsp_hit_r;
    logic [ADDR_W-1:0]   rsp_idx_r;
    tcam_action_t        rsp_act_r;
    logic [TAG_W-1:0]    rsp_tag_r;
    logic [31:0]         lookup_cnt_r;
    logic [31:0]         hit_cnt_r;

    assign clr_busy_s   = (state_r == ST_CLEAR);
    assign stall_s      = rsp_valid_r && !rsp_ready;
    assign req_ready    = !rst && !stall_s && !clr_busy_s;
    assign accept_s     = req_valid && req_ready;
    assign rsp_fire_s   = rsp_valid_r && rsp_ready;
    assign clr_accept_s = clr_start && (state_r == ST_IDLE);
    assign wr_en_s      = wr_en && !clr_busy_s;

    assign wr_act_s.action_id  = wr_action_id;
    assign wr_act_s.action_ptr = wr_action_ptr;

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        mau_tcam_bank #(
            .KEY_W   (KEY_W),
            .ENT     (ENT),
            .ADDR_W  (ADDR_W),
            .LADDR_W (LADDR_W),
            .BANK_ID (b)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (wr_en_s),
            .wr_addr   (wr_addr),
            .wr_key    (wr_key),
            .wr_mask   (wr_mask),
            .wr_action (wr_act_s),
            .wr_valid  (wr_valid),
            .clr_en    (clr_busy_s),
            .clr_addr  (clr_addr_r),
            .cap_en    (!stall_s),
            .key       (req_key),
            .hit       (bank_hit_s[b]),
            .idx       (bank_idx_s[b]),
            .action    (bank_act_s[b])
        );
    end

    // Stage-A control: valid and tag travel alongside the per-bank snapshots
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_r <= 1'b0;
            a_tag_r   <= '0;
        end else if (!stall_s) begin
            a_valid_r <= accept_s;
            a_tag_r   <= req_tag;
        end
    end

    // Stage-B bank arbitration: lowest-numbered hitting bank owns the lowest index
    always_comb begin
        sel_hit_s            = 1'b0;
        sel_idx_s            = '0;
        sel_act_s.action_id  = miss_action_id;
        sel_act_s.action_ptr = miss_action_ptr;
        for (int b = BANKS - 1; b >= 0; b--) begin
            if (bank_hit_s[b]) begin
                sel_hit_s = 1'b1;
                sel_idx_s = ADDR_W'(unsigned'(b) * ENT) + ADDR_W'(bank_idx_s[b]);
                sel_act_s = bank_act_s[b];
            end else begin
                sel_hit_s = sel_hit_s;
            end
        end
    end

    // Stage-B response register; frozen while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_hit_r   <= 1'b0;
            rsp_idx_r   <= '0;
            rsp_act_r   <= '0;
            rsp_tag_r   <= '0;
        end else if (!stall_s) begin
            rsp_valid_r <= a_valid_r;
            if (a_valid_r) begin
                rsp_hit_r <= sel_hit_s;
                rsp_idx_r <= sel_idx_s;
                rsp_act_r <= sel_act_s;
                rsp_tag_r <= a_tag_r;
            end
        end
    end

    // Valid-bit sweep: one entry per cycle, DEPTH cycles total
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            clr_addr_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (clr_start) begin
                        state_r    <= ST_CLEAR;
                        clr_addr_r <= '0;
                    end
                end
                ST_CLEAR: begin
                    clr_addr_r <= clr_addr_r + ADDR_W'(1);
                    if (clr_addr_r == ADDR_W'(DEPTH - 1)) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    clr_addr_r <= '0;
                end
            endcase
        end
    end

    // Saturating statistics; a clear start wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst) begin
            lookup_cnt_r <= 32'd0;
            hit_cnt_r    <= 32'd0;
        end else if (clr_accept_s) begin
            lookup_cnt_r <= 32'd0;
            hit_cnt_r    <= 32'd0;
        end else if (rsp_fire_s) begin
            if (lookup_cnt_r != 32'hFFFF_FFFF) begin
                lookup_cnt_r <= lookup_cnt_r + 32'd1;
            end
            if (rsp_hit_r && (hit_cnt_r != 32'hFFFF_FFFF)) begin
                hit_cnt_r <= hit_cnt_r + 32'd1;
            end
        end
    end

    assign rsp_valid      = rsp_valid_r;
    assign rsp_hit        = rsp_hit_r;
    assign rsp_idx        = rsp_idx_r;
    assign rsp_action_id  = rsp_act_r.action_id;
    assign rsp_action_ptr = rsp_act_r.action_ptr;
    assign rsp_tag        = rsp_tag_r;
    assign clr_busy       = clr_busy_s;
    assign lookup_cnt     = lookup_cnt_r;
    assign hit_cnt        = hit_cnt_r;

endmodule

// File: tb/tb_mau_tcam_pipe.sv
// Directed self-checking bench for mau_tcam_pipe with hand-computed expectations.
module tb_mau_tcam_pipe;
    import rv_p4_pkg::*;

    localparam int KEY_W  = 512;
    localparam int DEPTH  = 2048;
    localparam int BANKS  = 4;
    localparam int TAG_W  = 8;
    localparam int ADDR_W = 11;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic [KEY_W-1:0]   req_key;
    logic [TAG_W-1:0]   req_tag;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_hit;
    logic [ADDR_W-1:0]  rsp_idx;
    logic [15:0]        rsp_action_id;
    logic [15:0]        rsp_action_ptr;
    logic [TAG_W-1:0]   rsp_tag;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [KEY_W-1:0]   wr_key;
    logic [KEY_W-1:0]   wr_mask;
    logic [15:0]        wr_action_id;
    logic [15:0]        wr_action_ptr;
    logic               wr_valid;
    logic [15:0]        miss_action_id;
    logic [15:0]        miss_action_ptr;
    logic               clr_start;
    logic               clr_busy;
    logic [31:0]        lookup_cnt;
    logic [31:0]        hit_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mau_tcam_pipe #(
        .KEY_W (KEY_W),
        .DEPTH (DEPTH),
        .BANKS (BANKS),
        .TAG_W (TAG_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_key         (req_key),
        .req_tag         (req_tag),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_hit         (rsp_hit),
        .rsp_idx         (rsp_idx),
        .rsp_action_id   (rsp_action_id),
        .rsp_action_ptr  (rsp_action_ptr),
        .rsp_tag         (rsp_tag),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_key          (wr_key),
        .wr_mask         (wr_mask),
        .wr_action_id    (wr_action_id),
        .wr_action_ptr   (wr_action_ptr),
        .wr_valid        (wr_valid),
        .miss_action_id  (miss_action_id),
        .miss_action_ptr (miss_action_ptr),
        .clr_start       (clr_start),
        .clr_busy        (clr_busy),
        .lookup_cnt      (lookup_cnt),
        .hit_cnt         (hit_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int idx, input logic [KEY_W-1:0] key, input logic [KEY_W-1:0] mask,
                               input logic [15:0] id, input logic [15:0] ptr, input logic v);
        wr_en         = 1'b1;
        wr_addr       = ADDR_W'(idx);
        wr_key        = key;
        wr_mask       = mask;
        wr_action_id  = id;
        wr_action_ptr = ptr;
        wr_valid      = v;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_lookup(input string name, input logic [KEY_W-1:0] key, input logic [7:0] tag,
                             input logic exp_hit, input int exp_idx, input logic [15:0] exp_id,
                             input logic [15:0] exp_ptr);
        check_eq({name, "_ready"}, {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_key   = key;
        req_tag   = tag;
        tick();
        req_valid = 1'b0;
        check_eq({name, "_lat1"}, {63'd0, rsp_valid}, 64'd0);
        tick();
        check_eq({name, "_valid"}, {63'd0, rsp_valid}, 64'd1);
        check_eq({name, "_hit"}, {63'd0, rsp_hit}, {63'd0, exp_hit});
        check_eq({name, "_idx"}, 64'(rsp_idx), 64'(exp_idx));
        check_eq({name, "_id"}, 64'(rsp_action_id), 64'(exp_id));
        check_eq({name, "_ptr"}, 64'(rsp_action_ptr), 64'(exp_ptr));
        check_eq({name, "_tag"}, 64'(rsp_tag), 64'(tag));
        tick();
    endtask

    logic [KEY_W-1:0] b2b_key [4];
    logic             b2b_hit [4];
    int               b2b_idx [4];
    int               busy_cycles;
    int               sent;
    int               got;
    int               stall_left;
    bit               stall_done;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_key = '0; req_tag = '0; rsp_ready = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_key = '0; wr_mask = '0; wr_action_id = 16'h0000;
        wr_action_ptr = 16'h0000; wr_valid = 1'b0; clr_start = 1'b0;
        miss_action_id = 16'h0007; miss_action_ptr = 16'h0077;
        repeat (3) tick();
        check_eq("rst_req_ready", {63'd0, req_ready}, 64'd0);
        check_eq("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check_eq("rst_clr_busy", {63'd0, clr_busy}, 64'd0);
        check_eq("rst_lookup_cnt", 64'(lookup_cnt), 64'd0);
        check_eq("rst_hit_cnt", 64'(hit_cnt), 64'd0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready", {63'd0, req_ready}, 64'd1);

        // Empty table returns the miss action
        do_lookup("empty", 512'hAB, 8'h10, 1'b0, 0, 16'h0007, 16'h0077);
        check_eq("empty_lookup_cnt", 64'(lookup_cnt), 64'd1);
        check_eq("empty_hit_cnt", 64'(hit_cnt), 64'd0);

        // Exact and masked entries; lowest index wins when both match
        write_entry(5, 512'hAB, 512'h0, 16'h0011, 16'h0105, 1'b1);
        write_entry(9, 512'hA0, 512'h0F, 16'h0022, 16'h0109, 1'b1);
        do_lookup("ab", 512'hAB, 8'h11, 1'b1, 5, 16'h0011, 16'h0105);
        do_lookup("a3", 512'hA3, 8'h12, 1'b1, 9, 16'h0022, 16'h0109);
        do_lookup("b0", 512'hB0, 8'h13, 1'b0, 0, 16'h0007, 16'h0077);
        check_eq("cnt4_lookup", 64'(lookup_cnt), 64'd4);
        check_eq("cnt4_hit", 64'(hit_cnt), 64'd2);

        // Write and stage-A capture on the same edge: old contents seen
        req_valid = 1'b1; req_key = 512'hC3; req_tag = 8'h30;
        wr_en = 1'b1; wr_addr = 11'd3; wr_key = 512'hC3; wr_mask = 512'h0;
        wr_action_id = 16'h0033; wr_action_ptr = 16'h0103; wr_valid = 1'b1;
        tick();
        wr_en = 1'b0; req_tag = 8'h31;
        tick();
        req_valid = 1'b0;
        check_eq("race_first_valid", {63'd0, rsp_valid}, 64'd1);
        check_eq("race_first_hit", {63'd0, rsp_hit}, 64'd0);
        check_eq("race_first_tag", 64'(rsp_tag), 64'h30);
        tick();
        check_eq("race_second_valid", {63'd0, rsp_valid}, 64'd1);
        check_eq("race_second_hit", {63'd0, rsp_hit}, 64'd1);
        check_eq("race_second_idx", 64'(rsp_idx), 64'd3);
        check_eq("race_second_tag", 64'(rsp_tag), 64'h31);
        tick();

        // Back-to-back lookups with a three-cycle stall from the second response
        b2b_key[0] = 512'hAB; b2b_hit[0] = 1'b1; b2b_idx[0] = 5;
        b2b_key[1] = 512'hA3; b2b_hit[1] = 1'b1; b2b_idx[1] = 9;
        b2b_key[2] = 512'hB0; b2b_hit[2] = 1'b0; b2b_idx[2] = 0;
        b2b_key[3] = 512'hC3; b2b_hit[3] = 1'b1; b2b_idx[3] = 3;
        sent = 0; got = 0; stall_left = 0; stall_done = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            if (rsp_valid && got == 1 && !stall_done) begin
                stall_left = 3;
                stall_done = 1'b1;
            end
            rsp_ready = (stall_left == 0);
            req_valid = (sent < 4);
            req_key   = b2b_key[(sent < 4) ? sent : 0];
            req_tag   = 8'(sent);
            #1;
            if (stall_left > 0) begin
                check_eq("stall_req_ready", {63'd0, req_ready}, 64'd0);
                check_eq("stall_tag_hold", 64'(rsp_tag), 64'd1);
            end
            if (rsp_valid && rsp_ready) begin
                check_eq("b2b_tag", 64'(rsp_tag), 64'(got));
                check_eq("b2b_hit", {63'd0, rsp_hit}, {63'd0, b2b_hit[got]});
                check_eq("b2b_idx", 64'(rsp_idx), 64'(b2b_idx[got]));
                got++;
            end
            if (req_valid && req_ready) begin
                sent++;
            end
            if (stall_left > 0) begin
                stall_left--;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        check_eq("b2b_got", 64'(got), 64'd4);
        check_eq("b2b_sent", 64'(sent), 64'd4);
        check_eq("b2b_stalled", {63'd0, stall_done}, 64'd1);
        tick();
        check_eq("b2b_no_dup", {63'd0, rsp_valid}, 64'd0);
        check_eq("cnt10_lookup", 64'(lookup_cnt), 64'd10);
        check_eq("cnt10_hit", 64'(hit_cnt), 64'd6);

        // Cross-bank priority and the index boundaries
        write_entry(600, 512'h1234_5678, 512'h0, 16'h0600, 16'h0601, 1'b1);
        write_entry(1500, 512'h1234_5678, 512'h0, 16'h1500, 16'h1501, 1'b1);
        do_lookup("bank1", 512'h1234_5678, 8'h40, 1'b1, 600, 16'h0600, 16'h0601);
        write_entry(600, 512'h1234_5678, 512'h0, 16'h0600, 16'h0601, 1'b0);
        do_lookup("bank2", 512'h1234_5678, 8'h41, 1'b1, 1500, 16'h1500, 16'h1501);
        write_entry(2047, 512'hFEED, 512'h0, 16'h07FF, 16'h17FF, 1'b1);
        do_lookup("top_idx", 512'hFEED, 8'h42, 1'b1, 2047, 16'h07FF, 16'h17FF);
        write_entry(0, 512'hFEED, 512'h0, 16'h0AAA, 16'h0BBB, 1'b1);
        do_lookup("zero_idx", 512'hFEED, 8'h43, 1'b1, 0, 16'h0AAA, 16'h0BBB);
        check_eq("cnt14_lookup", 64'(lookup_cnt), 64'd14);
        check_eq("cnt14_hit", 64'(hit_cnt), 64'd10);

        // Pending response consumed on the same edge the sweep starts
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_key = 512'hAB; req_tag = 8'h50;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check_eq("hold_valid", {63'd0, rsp_valid}, 64'd1);
        check_eq("hold_tag", 64'(rsp_tag), 64'h50);
        check_eq("hold_idx", 64'(rsp_idx), 64'd5);
        rsp_ready = 1'b1;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        check_eq("clr_lookup_zero", 64'(lookup_cnt), 64'd0);
        check_eq("clr_hit_zero", 64'(hit_cnt), 64'd0);
        check_eq("clr_busy_on", {63'd0, clr_busy}, 64'd1);
        check_eq("clr_rsp_done", {63'd0, rsp_valid}, 64'd0);
        busy_cycles = 0;
        while (clr_busy && busy_cycles < 5000) begin
            busy_cycles++;
            if (busy_cycles == 10) begin
                wr_en = 1'b1; wr_addr = 11'd7; wr_key = 512'h55; wr_mask = 512'h0;
                wr_action_id = 16'h0055; wr_action_ptr = 16'h0155; wr_valid = 1'b1;
            end else begin
                wr_en = 1'b0;
            end
            clr_start = (busy_cycles == 100);
            if (busy_cycles == 20) begin
                check_eq("clr_req_ready", {63'd0, req_ready}, 64'd0);
            end
            tick();
        end
        wr_en = 1'b0;
        clr_start = 1'b0;
        check_eq("clr_busy_cycles", 64'(busy_cycles), 64'd2048);
        do_lookup("post_clr_ab", 512'hAB, 8'h60, 1'b0, 0, 16'h0007, 16'h0077);
        do_lookup("post_clr_1500", 512'h1234_5678, 8'h61, 1'b0, 0, 16'h0007, 16'h0077);
        do_lookup("post_clr_feed", 512'hFEED, 8'h62, 1'b0, 0, 16'h0007, 16'h0077);
        do_lookup("post_clr_wr7", 512'h55, 8'h63, 1'b0, 0, 16'h0007, 16'h0077);
        check_eq("post_clr_lookup", 64'(lookup_cnt), 64'd4);
        check_eq("post_clr_hit", 64'(hit_cnt), 64'd0);

        // Reset mid-lookup drops the in-flight response
        write_entry(12, 512'h99, 512'h0, 16'h0099, 16'h0199, 1'b1);
        req_valid = 1'b1; req_key = 512'h99; req_tag = 8'h70;
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_flight_valid0", {63'd0, rsp_valid}, 64'd0);
        tick();
        check_eq("rst_flight_valid1", {63'd0, rsp_valid}, 64'd0);
        check_eq("rst_flight_cnt", 64'(lookup_cnt), 64'd0);
        do_lookup("rst_valid_bits", 512'h99, 8'h71, 1'b0, 0, 16'h0007, 16'h0077);

        // Reset mid-sweep aborts it
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (5) tick();
        check_eq("sweep_busy", {63'd0, clr_busy}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_eq("sweep_abort_busy", {63'd0, clr_busy}, 64'd0);
        check_eq("sweep_abort_ready", {63'd0, req_ready}, 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mau_tcam_pipe.md
MAU_TCAM_PIPE -- requirements
Module: mau_tcam_pipe

Interface
REQ-001 SHALL have parameters:
- KEY_W, default MAU_TCAM_KEY_W (512), key width.
- DEPTH, default MAU_TCAM_DEPTH (2048), entries, power of 2.
- BANKS, default 4, power of 2, divides DEPTH.
- TAG_W, default 8, request tag width.
- ADDR_W = $clog2(DEPTH), derived.

REQ-002 SHALL have ports, one clock; reset is synchronous and active-high:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  lookup request
- req_ready  out  1  request accepted when req_valid&&req_ready
- req_key  in  KEY_W  lookup key
- req_tag  in  TAG_W  opaque tag
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready
- rsp_hit  out  1  any entry matched
- rsp_idx  out  ADDR_W  winning entry index (0 on miss)
- rsp_action_id  out  16  action id
- rsp_action_ptr  out  16  action pointer
- rsp_tag  out  TAG_W  tag of the request
- wr_en  in  1  entry write strobe
- wr_addr  in  ADDR_W  entry index
- wr_key, wr_mask  in  KEY_W  entry key; mask bit 1 = don't care
- wr_action_id, wr_action_ptr  in  16  entry action
- wr_valid  in  1  entry valid bit
- miss_action_id, miss_action_ptr  in  16  default action returned on miss
- clr_start  in  1  start valid-bit sweep
- clr_busy  out  1  sweep in progress
- lookup_cnt, hit_cnt  out  32  saturating statistics

Function
REQ-003 Entry i SHALL match when valid[i] && ((key^t_key[i]) & ~t_mask[i]) == 0.
REQ-004 Banks SHALL be contiguous ranges: bank b holds indices b*DEPTH/BANKS .. (b+1)*DEPTH/BANKS-1.
REQ-005 Stage A (first edge after accept) SHALL register, per bank: hit flag, lowest matching local index, and that entry's action id/ptr. Stage A also carries tag and a valid bit.
REQ-006 Stage B SHALL select the lowest-numbered hitting bank, forming the lowest global index. It SHALL register rsp_* from that selection, or {hit=0, idx=0, miss_action_*} on miss.
REQ-007 Latency: rsp_valid SHALL assert 2 cycles after accept when unstalled. Throughput is 1 lookup/cycle. Responses are in order.
REQ-008 stall = rsp_valid && !rsp_ready. On stall, stages A and B SHALL hold all contents and rsp_* SHALL stay stable.
REQ-009 req_ready = !rst && !stall && !clr_busy.
REQ-010 A write at edge t SHALL be visible to stage-A evaluations at edge t+1 and later. A stage-A capture at edge t SHALL see the old contents. Responses SHALL use action fields from the stage-A snapshot.
REQ-011 wr_en SHALL be ignored while clr_busy=1.
REQ-012 Clear FSM has states IDLE and CLEAR:
- IDLE->CLEAR on clr_start: addr=0, clr_busy=1.
- In CLEAR, valid[addr] is cleared each cycle and addr increments.
- CLEAR->IDLE after addr=DEPTH-1, so clr_busy is high for exactly DEPTH cycles.
- clr_start while in CLEAR is ignored.
REQ-013 Lookups already in stages A/B when clear starts SHALL complete with their snapshot results.
REQ-014 On each response handshake, lookup_cnt SHALL increment, and hit_cnt SHALL also increment if rsp_hit. Both saturate at 32'hFFFF_FFFF.
REQ-015 Both counters SHALL be zeroed on the cycle after clr_start is accepted in IDLE. An increment in that same cycle is dropped.

Reset
REQ-016 While rst=1 at an edge, the following SHALL be cleared: all valid bits, stage A/B valids, rsp_valid=0, rsp_* data=0, FSM=IDLE, clr_busy=0, counters=0.
REQ-017 Key, mask and action arrays SHALL NOT be reset.
REQ-018 Reset mid-lookup or mid-clear SHALL discard in-flight responses and abort the sweep.

Structure
REQ-019 rv_p4_pkg SHALL hold MAU_TCAM_KEY_W and MAU_TCAM_DEPTH, plus typedef tcam_action_t {action_id[15:0], action_ptr[15:0]}.
REQ-020 A sub-module mau_tcam_bank SHALL implement storage and match with a local priority encoder, instantiated BANKS times. Stage B and the FSM live in the top.

Verification
REQ-021 Write idx 5 key=0xAB mask=0 action 0x11, and idx 9 key=0xA0 mask=0x0F action 0x22; lookup key 0xAB -> after 2 cycles hit=1, idx=5, action_id=0x11.
REQ-022 Empty table, miss_action_id=0x7 -> hit=0, idx=0, action_id=0x7; lookup_cnt=1, hit_cnt=0.
REQ-023 Back-to-back 4 lookups with rsp_ready low for 3 cycles from the 2nd response -> req_ready low during stall; tags returned 0,1,2,3 in order; no drops or duplicates.
REQ-024 Write idx 600 (bank 1) and idx 1500 (bank 2) with the same key -> idx=600. Invalidate 600 -> idx=1500.
REQ-025 Write idx 3 at edge t while a lookup of its key is captured in stage A at edge t -> that lookup misses; the next lookup hits idx 3.
REQ-026 clr_start with DEPTH=2048 -> clr_busy high for 2048 cycles, req_ready=0, wr_en ignored, counters zeroed; afterwards all lookups miss.
